// File: rtl/spi_word_master.sv
// SPI master: serialises one DATA_WIDTH word per transaction with programmable
// CS setup/hold, any SPI mode and MSB/LSB-first order. All outputs registered.
//
// state      | meaning
// S_IDLE     | ready for a word; CS deasserted, SCLK at CPOL
// S_CS_SETUP | CS asserted, waiting CS_SETUP_CLKS before the first half period
// S_SHIFT    | generating 2*DATA_WIDTH SCLK edges, shifting MOSI/MISO
// S_CS_HOLD  | SCLK idle, CS still asserted for CS_HOLD_CLKS
module spi_word_master #(
  parameter int DATA_WIDTH        = 12,
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_SETUP_CLKS     = 1,
  parameter int CS_HOLD_CLKS      = 1,
  parameter int NUM_CS            = 1,
  parameter int LSB_FIRST         = 0,
  localparam int CSW              = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [DATA_WIDTH-1:0] i_TX_Word,
  input  logic [CSW-1:0]        i_TX_CS,
  input  logic                  i_TX_DV,
  output logic                  o_TX_Ready,
  output logic [DATA_WIDTH-1:0] o_RX_Word,
  output logic                  o_RX_DV,
  output logic                  o_SPI_Clk,
  output logic                  o_SPI_MOSI,
  input  logic                  i_SPI_MISO,
  output logic [NUM_CS-1:0]     o_SPI_CS_n
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
  localparam int   EW   = $clog2(2 * DATA_WIDTH);
  localparam int   TW   = 16;

  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);
  localparam logic [TW-1:0] SETUP_LD  = TW'(CS_SETUP_CLKS - 1);
  localparam logic [TW-1:0] HALF_LD   = TW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(CS_HOLD_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CS_SETUP, S_SHIFT, S_CS_HOLD} state_t;

  state_t                  state_q, state_nx;
  logic [TW-1:0]           timer_q;
  logic [EW-1:0]           edge_q;
  logic [DATA_WIDTH-1:0]   tx_sr_q, rx_sr_q, rx_word_q;
  logic                    sclk_q, mosi_q, rx_dv_q, ready_q;
  logic [NUM_CS-1:0]       cs_n_q;

  logic                    accept, tc, sclk_edge, last_edge, sample_en, shift_en, done;
  logic [NUM_CS-1:0]       cs_dec;

  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  // Received bits land in the same order they were transmitted.
  function automatic logic [DATA_WIDTH-1:0] insert(input logic [DATA_WIDTH-1:0] v,
                                                   input logic b);
    return (LSB_FIRST != 0) ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
  endfunction

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:     if (accept)    state_nx = S_CS_SETUP;
      S_CS_SETUP: if (tc)        state_nx = S_SHIFT;
      S_SHIFT:    if (last_edge) state_nx = S_CS_HOLD;
      S_CS_HOLD:  if (tc)        state_nx = S_IDLE;
      default:                   state_nx = S_IDLE;
    endcase
  end

  // Even edge index = leading edge of a bit, odd = trailing.
  always_comb begin
    accept    = (state_q == S_IDLE) && ready_q && i_TX_DV;
    tc        = (timer_q == '0);
    sclk_edge = (state_q == S_SHIFT) && tc;
    last_edge = sclk_edge && (edge_q == LAST_EDGE);
    sample_en = sclk_edge && (CPHA ? edge_q[0] : !edge_q[0]);
    shift_en  = sclk_edge && (CPHA ? !edge_q[0] : (edge_q[0] && !last_edge));
    done      = (state_q == S_CS_HOLD) && tc;
    cs_dec    = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (i_TX_CS == CSW'(i)) cs_dec[i] = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      timer_q   <= '0;
      edge_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_word_q <= '0;
      sclk_q    <= CPOL;
      mosi_q    <= 1'b0;
      rx_dv_q   <= 1'b0;
      ready_q   <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      ready_q <= (state_nx == S_IDLE);
      rx_dv_q <= done;
      if (accept) begin
        timer_q <= SETUP_LD;
        edge_q  <= '0;
        cs_n_q  <= cs_dec;
        rx_sr_q <= '0;
        // CPHA=0 presents the first bit during setup; CPHA=1 waits for the leading edge.
        tx_sr_q <= CPHA ? i_TX_Word : advance(i_TX_Word);
        mosi_q  <= CPHA ? 1'b0 : head_bit(i_TX_Word);
      end else begin
        if (state_q != S_IDLE) begin
          if (!tc)                          timer_q <= timer_q - TW'(1);
          else if (state_q == S_CS_SETUP)   timer_q <= HALF_LD;
          else if (state_q == S_SHIFT)      timer_q <= last_edge ? HOLD_LD : HALF_LD;
        end
        if (sclk_edge) begin
          sclk_q <= ~sclk_q;
          if (!last_edge) edge_q <= edge_q + EW'(1);
        end
        if (shift_en) begin
          mosi_q  <= head_bit(tx_sr_q);
          tx_sr_q <= advance(tx_sr_q);
        end
        if (sample_en) rx_sr_q <= insert(rx_sr_q, i_SPI_MISO);
        if (done) begin
          cs_n_q    <= '1;
          mosi_q    <= 1'b0;
          rx_word_q <= rx_sr_q;
        end
      end
    end
  end

  assign o_TX_Ready = ready_q;
  assign o_RX_Word  = rx_word_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_SPI_Clk  = sclk_q;
  assign o_SPI_MOSI = mosi_q;
  assign o_SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_word_master.sv
// Directed bench for spi_word_master: four parameterisations share the stimulus;
// one is observed per transfer through a small selection mux.
module tb_spi_word_master;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [11:0] tx_word = '0;
  logic [2:0]  tx_cs = '0;
  logic        tx_dv = 1'b0;

  logic a_rdy, a_rxdv, a_sclk, a_mosi, a_miso;  logic [11:0] a_rxw; logic [0:0] a_csn;
  logic b_rdy, b_rxdv, b_sclk, b_mosi;          logic [11:0] b_rxw; logic [0:0] b_csn;
  logic c_rdy, c_rxdv, c_sclk, c_mosi, c_miso;  logic [11:0] c_rxw; logic [3:0] c_csn;
  logic d_rdy, d_rxdv, d_sclk, d_mosi, d_miso;  logic [11:0] d_rxw; logic [5:0] d_csn;
  logic b_miso = 1'b0;
  logic [11:0] sl_word = 12'h81F;
  logic [11:0] sl_sr = '0;

  always #5 clk = ~clk;

  assign a_miso = a_mosi;
  assign c_miso = c_mosi;
  assign d_miso = d_mosi;

  // Mode-3 slave: loads on CS fall, drives next bit on each falling (leading) SCLK edge.
  always @(negedge b_csn[0]) sl_sr = sl_word;
  always @(negedge b_sclk) begin
    if (!b_csn[0]) begin
      b_miso = sl_sr[11];
      sl_sr  = sl_sr << 1;
    end
  end

  spi_word_master #(.SPI_MODE(0)) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Word(tx_word), .i_TX_CS(tx_cs[0:0]), .i_TX_DV(tx_dv),
    .o_TX_Ready(a_rdy), .o_RX_Word(a_rxw), .o_RX_DV(a_rxdv), .o_SPI_Clk(a_sclk),
    .o_SPI_MOSI(a_mosi), .i_SPI_MISO(a_miso), .o_SPI_CS_n(a_csn));

  spi_word_master #(.SPI_MODE(3)) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Word(tx_word), .i_TX_CS(tx_cs[0:0]), .i_TX_DV(tx_dv),
    .o_TX_Ready(b_rdy), .o_RX_Word(b_rxw), .o_RX_DV(b_rxdv), .o_SPI_Clk(b_sclk),
    .o_SPI_MOSI(b_mosi), .i_SPI_MISO(b_miso), .o_SPI_CS_n(b_csn));

  spi_word_master #(.NUM_CS(4), .LSB_FIRST(1)) dut_c (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Word(tx_word), .i_TX_CS(tx_cs[1:0]), .i_TX_DV(tx_dv),
    .o_TX_Ready(c_rdy), .o_RX_Word(c_rxw), .o_RX_DV(c_rxdv), .o_SPI_Clk(c_sclk),
    .o_SPI_MOSI(c_mosi), .i_SPI_MISO(c_miso), .o_SPI_CS_n(c_csn));

  spi_word_master #(.NUM_CS(6)) dut_d (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_TX_Word(tx_word), .i_TX_CS(tx_cs), .i_TX_DV(tx_dv),
    .o_TX_Ready(d_rdy), .o_RX_Word(d_rxw), .o_RX_DV(d_rxdv), .o_SPI_Clk(d_sclk),
    .o_SPI_MOSI(d_mosi), .i_SPI_MISO(d_miso), .o_SPI_CS_n(d_csn));

  int          sel = 0;
  logic        o_rdy, o_sclk, o_mosi, o_rxdv;
  logic [11:0] o_rxw;
  logic [7:0]  o_csn;

  always_comb begin
    o_rdy = a_rdy; o_sclk = a_sclk; o_mosi = a_mosi; o_rxdv = a_rxdv; o_rxw = a_rxw;
    o_csn = {7'h7F, a_csn};
    case (sel)
      1: begin o_rdy = b_rdy; o_sclk = b_sclk; o_mosi = b_mosi; o_rxdv = b_rxdv; o_rxw = b_rxw;
               o_csn = {7'h7F, b_csn}; end
      2: begin o_rdy = c_rdy; o_sclk = c_sclk; o_mosi = c_mosi; o_rxdv = c_rxdv; o_rxw = c_rxw;
               o_csn = {4'hF, c_csn}; end
      3: begin o_rdy = d_rdy; o_sclk = d_sclk; o_mosi = d_mosi; o_rxdv = d_rxdv; o_rxw = d_rxw;
               o_csn = {2'b11, d_csn}; end
      default: ;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          r_cs_low, r_rises, r_rise_chg, r_rxcnt, r_first_rise_n, r_rxdv_n, r_gap, r_overlap;
  logic [31:0] r_cap;
  logic        r_first_bit, r_end_sclk;
  logic [7:0]  r_cs_pat;
  logic [11:0] r_rxw [2];

  // Send w0 (and w1 back-to-back when nw==2) and record what the selected DUT does,
  // sampling on falling clock edges; n counts samples after the accepting edge.
  task automatic xfer(input int s, input logic [11:0] w0, input logic [11:0] w1,
                      input int nw, input logic [2:0] idx, input int pulse_n);
    logic prev_sclk, prev_mosi, cs_prev_low, cs_low_now, drop;
    int   high_start;
    sel = s;
    @(negedge clk);
    for (int k = 0; k < 200 && !o_rdy; k++) @(negedge clk);
    check("ready_before_send", o_rdy, 1);
    r_cs_low = 0; r_rises = 0; r_rise_chg = 0; r_rxcnt = 0; r_first_rise_n = -1;
    r_rxdv_n = -1; r_gap = -1; r_overlap = 0; r_cap = '0; r_first_bit = 1'b0;
    r_cs_pat = 8'hFF; r_rxw[0] = '0; r_rxw[1] = '0;
    prev_sclk = o_sclk; prev_mosi = o_mosi; cs_prev_low = 1'b1; high_start = 0; drop = 1'b0;
    tx_word = w0; tx_cs = idx; tx_dv = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= ((nw == 2) ? 112 : 60); n++) begin
      @(negedge clk);
      cs_low_now = (o_csn != 8'hFF);
      if (cs_low_now) begin
        r_cs_low++;
        r_cs_pat = o_csn;
        if (o_rdy) r_overlap++;
      end
      if (!cs_low_now && cs_prev_low) high_start = n;
      if (cs_low_now && !cs_prev_low) r_gap = n - high_start;
      cs_prev_low = cs_low_now;
      if (!prev_sclk && o_sclk) begin
        r_rises++;
        r_cap = {r_cap[30:0], o_mosi};
        if (r_rises == 1) begin r_first_bit = o_mosi; r_first_rise_n = n; end
        if (o_mosi != prev_mosi) r_rise_chg++;
      end
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
      if (o_rxdv) begin
        if (r_rxcnt < 2) r_rxw[r_rxcnt] = o_rxw;
        if (r_rxcnt == 0) r_rxdv_n = n;
        r_rxcnt++;
      end
      if (nw == 1) begin
        if (n == 1) tx_dv = 1'b0;
        if (n == pulse_n) begin tx_word = 12'h555; tx_dv = 1'b1; end
        if (n == pulse_n + 1) tx_dv = 1'b0;
      end else begin
        if (n == 1) tx_word = w1;
        if (drop) tx_dv = 1'b0;
        else if (n >= 2 && tx_dv && o_rdy) drop = 1'b1;
      end
    end
    r_end_sclk = o_sclk;
    tx_dv = 1'b0;
  endtask

  int rst_dv_cnt;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", a_rdy, 0);
    check("rst_cs_n", a_csn, 1);
    check("rst_sclk_m0", a_sclk, 0);
    check("rst_sclk_m3", b_sclk, 1);
    check("rst_mosi", a_mosi, 0);
    check("rst_rx_dv", a_rxdv, 0);
    check("rst_rx_word", a_rxw, 0);
    check("rst_cs_n_multi", d_csn, 6'h3F);
    rst_l = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", a_rdy, 1);

    // Mode 0, loopback, 0xA5C
    xfer(0, 12'hA5C, 12'h000, 1, 3'd0, 0);
    check("m0_mosi_seq", r_cap[11:0], 12'hA5C);
    check("m0_rises", r_rises, 12);
    check("m0_cs_low_cycles", r_cs_low, 50);
    check("m0_first_edge_n", r_first_rise_n, 4);
    check("m0_rx_dv_n", r_rxdv_n, 51);
    check("m0_rx_dv_count", r_rxcnt, 1);
    check("m0_rx_word", r_rxw[0], 12'hA5C);
    check("m0_mosi_on_rise", r_rise_chg, 0);
    check("m0_ready_busy", r_overlap, 0);
    check("m0_sclk_idle", r_end_sclk, 0);

    // Mode 3 with slave returning 0x81F
    xfer(1, 12'h3F0, 12'h000, 1, 3'd0, 0);
    check("m3_mosi_seq", r_cap[11:0], 12'h3F0);
    check("m3_mosi_on_rise", r_rise_chg, 0);
    check("m3_rx_word", r_rxw[0], 12'h81F);
    check("m3_cs_low_cycles", r_cs_low, 50);
    check("m3_sclk_idle", r_end_sclk, 1);

    // Back-to-back with TX_DV held high
    xfer(0, 12'h001, 12'hFFF, 2, 3'd0, 0);
    check("b2b_gap", r_gap, 1);
    check("b2b_rx_dv_count", r_rxcnt, 2);
    check("b2b_rx_word0", r_rxw[0], 12'h001);
    check("b2b_rx_word1", r_rxw[1], 12'hFFF);
    check("b2b_mosi_seq", r_cap[23:0], 24'h001FFF);
    check("b2b_ready_busy", r_overlap, 0);
    check("b2b_cs_low_cycles", r_cs_low, 100);

    // TX_DV pulse while busy is ignored
    xfer(0, 12'h3C6, 12'h000, 1, 3'd0, 10);
    check("busy_mosi_seq", r_cap[11:0], 12'h3C6);
    check("busy_rx_word", r_rxw[0], 12'h3C6);
    check("busy_rx_dv_count", r_rxcnt, 1);
    check("busy_cs_low_cycles", r_cs_low, 50);

    // Reset during bit 6
    sel = 0;
    @(negedge clk);
    tx_word = 12'h7E4; tx_cs = 3'd0; tx_dv = 1'b1;
    @(posedge clk);
    @(negedge clk); tx_dv = 1'b0;
    repeat (27) @(negedge clk);
    rst_l = 1'b0;
    #1;
    check("midrst_cs_n", a_csn, 1);
    check("midrst_sclk_m0", a_sclk, 0);
    check("midrst_sclk_m3", b_sclk, 1);
    check("midrst_mosi", a_mosi, 0);
    check("midrst_ready", a_rdy, 0);
    check("midrst_rx_word", a_rxw, 0);
    rst_dv_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 5) rst_l = 1'b1;
      if (a_rxdv) rst_dv_cnt++;
    end
    check("midrst_no_rx_dv", rst_dv_cnt, 0);
    xfer(0, 12'h6B1, 12'h000, 1, 3'd0, 0);
    check("postrst_mosi_seq", r_cap[11:0], 12'h6B1);
    check("postrst_rx_word", r_rxw[0], 12'h6B1);

    // NUM_CS=4, LSB first, CS 2
    xfer(2, 12'h001, 12'h000, 1, 3'd2, 0);
    check("lsb_cs_pattern", r_cs_pat, 8'hFB);
    check("lsb_first_bit", r_first_bit, 1);
    check("lsb_mosi_seq", r_cap[11:0], 12'h800);
    check("lsb_rx_word", r_rxw[0], 12'h001);

    // NUM_CS=6: highest valid index, then out-of-range index
    xfer(3, 12'h2B7, 12'h000, 1, 3'd5, 0);
    check("cs5_pattern", r_cs_pat, 8'hDF);
    check("cs5_mosi_seq", r_cap[11:0], 12'h2B7);
    xfer(3, 12'h9A3, 12'h000, 1, 3'd6, 0);
    check("cs6_no_cs_low", r_cs_low, 0);
    check("cs6_rises", r_rises, 12);
    check("cs6_rx_dv_count", r_rxcnt, 1);
    check("cs6_rx_word", r_rxw[0], 12'h9A3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
